note_player: RTL and testbench



---
 rtl/note_player.sv | 217 +++++++++++++++++++++
 tb/tb_note_player.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// note_player: square-wave tone generator for one note command at a time.
// A command (pitch, octave, duration in ms) is accepted in IDLE, played for
// dur*tpm cycles, then followed by a silent GAP_MS*tpm-cycle articulation gap.
// The tick rate (tpm) is latched at accept, so later changes to
// ticks_per_milli only affect the next note.
module note_player #(
   parameter int GAP_MS = 10,
   parameter int DUR_W  = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      ticks_per_milli,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [3:0]       note_pitch,
   input  logic [2:0]       note_octave,
   input  logic [DUR_W-1:0] note_dur_ms,
   input  logic             stop,
   output logic             sound,
   output logic             busy,
   output logic             note_done,
   output logic [3:0]       cur_pitch
);

   // The ms counter serves both PLAY (up to dur-1) and GAP (up to GAP_MS-1).
   localparam int GAP_W = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
   localparam int MS_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
   localparam logic [MS_W-1:0] GAP_LAST = MS_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t state, state_next;

   // Command fields captured at accept
   logic [3:0]       pitch_q;
   logic [2:0]       octave_q;
   logic [DUR_W-1:0] dur_q;
   logic [15:0]      tpm_q;

   // Timing counters
   logic [15:0]      tick_cnt;
   logic [MS_W-1:0]  ms_cnt;
   logic [11:0]      half_cnt;
   logic             sound_q;

   // Derived control
   logic             accept;
   logic             leave;
   logic             tick_last;
   logic             play_last;
   logic             gap_last;
   logic             is_rest;
   logic [MS_W-1:0]  dur_last;
   logic [11:0]      half_base;
   logic [11:0]      half_shift;
   logic [11:0]      half;

   // Octave-0 half periods at 100 kHz, C..B; rests map to 0.
   // NOTE: this is a constant case table that synthesizes to logic, not a
   // memory, so there is no storage to reset or initialise.
   function automatic logic [11:0] octave0_half(input logic [3:0] p);
      logic [11:0] v;
      case (p)
         4'd1:    v = 12'd3058;
         4'd2:    v = 12'd2886;
         4'd3:    v = 12'd2724;
         4'd4:    v = 12'd2571;
         4'd5:    v = 12'd2427;
         4'd6:    v = 12'd2290;
         4'd7:    v = 12'd2162;
         4'd8:    v = 12'd2041;
         4'd9:    v = 12'd1926;
         4'd10:   v = 12'd1818;
         4'd11:   v = 12'd1716;
         4'd12:   v = 12'd1620;
         default: v = 12'd0;
      endcase
      return v;
   endfunction

   // Half period from the latched pitch/octave; never allowed to reach 0.
   assign half_base  = octave0_half(pitch_q);
   assign half_shift = half_base >> octave_q;
   assign half       = (half_shift == 12'd0) ? 12'd1 : half_shift;

   assign is_rest   = (pitch_q == 4'd0) || (pitch_q > 4'd12);
   assign accept    = note_valid && (state == IDLE) && !stop;
   assign dur_last  = MS_W'(dur_q) - MS_W'(1);
   assign tick_last = (tick_cnt == tpm_q - 16'd1);
   assign play_last = (ms_cnt == dur_last) && tick_last;
   assign gap_last  = (GAP_MS == 0) || ((ms_cnt == GAP_LAST) && tick_last);
   assign leave     = (state != IDLE) && (state_next != state);

   // State register
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept, note end, gap end and abort
   // NOTE: state_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = (note_dur_ms == '0) ? GAP : PLAY;
            end
         end
         PLAY: begin
            if (stop) begin
               state_next = IDLE;
            end else if (play_last) begin
               state_next = GAP;
            end
         end
         GAP: begin
            if (stop) begin
               state_next = IDLE;
            end else if (gap_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode from state and registered tone
   always_comb begin
      note_ready = 1'b0;
      busy       = 1'b0;
      note_done  = 1'b0;
      cur_pitch  = 4'd0;
      sound      = 1'b0;
      case (state)
         IDLE: begin
            note_ready = 1'b1;
         end
         PLAY: begin
            busy  = 1'b1;
            sound = sound_q;
            if (!is_rest) begin
               cur_pitch = pitch_q;
            end
         end
         GAP: begin
            busy      = 1'b1;
            note_done = gap_last && !stop;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Capture command fields at accept; tpm of 0 is treated as 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pitch_q  <= 4'd0;
         octave_q <= 3'd0;
         dur_q    <= '0;
         tpm_q    <= 16'd1;
      end else if (accept) begin
         pitch_q  <= note_pitch;
         octave_q <= note_octave;
         dur_q    <= note_dur_ms;
         tpm_q    <= (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
      end
   end

   // Millisecond timebase shared by PLAY and GAP; cleared on every transition
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= 16'd0;
         ms_cnt   <= '0;
      end else if (accept || leave) begin
         tick_cnt <= 16'd0;
         ms_cnt   <= '0;
      end else if (state != IDLE) begin
         if (tick_last) begin
            tick_cnt <= 16'd0;
            ms_cnt   <= ms_cnt + MS_W'(1);
         end else begin
            tick_cnt <= tick_cnt + 16'd1;
         end
      end
   end

   // Square-wave generator: starts low, toggles after every half period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_cnt <= 12'd0;
         sound_q  <= 1'b0;
      end else if (accept || leave) begin
         half_cnt <= 12'd0;
         sound_q  <= 1'b0;
      end else if ((state == PLAY) && !is_rest) begin
         if (half_cnt == half - 12'd1) begin
            half_cnt <= 12'd0;
            sound_q  <= ~sound_q;
         end else begin
            half_cnt <= half_cnt + 12'd1;
         end
      end
   end

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: checks note_player cycle by cycle against a timing model
// derived from note parameters (half period, play and gap lengths).
module tb_note_player;

   localparam int GAP_MS = 10;
   localparam int DUR_W  = 12;
   // {sound, busy, note_ready, note_done, cur_pitch} while idle
   localparam logic [7:0] IDLE_V = 8'b0010_0000;

   logic             clk = 1'b0;
   logic             rst;
   logic [15:0]      ticks_per_milli;
   logic             note_valid;
   logic             note_ready;
   logic [3:0]       note_pitch;
   logic [2:0]       note_octave;
   logic [DUR_W-1:0] note_dur_ms;
   logic             stop;
   logic             sound;
   logic             busy;
   logic             note_done;
   logic [3:0]       cur_pitch;

   logic [7:0]       obs;
   int               checks = 0;
   int               errors = 0;

   note_player #(.GAP_MS(GAP_MS), .DUR_W(DUR_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .ticks_per_milli (ticks_per_milli),
      .note_valid      (note_valid),
      .note_ready      (note_ready),
      .note_pitch      (note_pitch),
      .note_octave     (note_octave),
      .note_dur_ms     (note_dur_ms),
      .stop            (stop),
      .sound           (sound),
      .busy            (busy),
      .note_done       (note_done),
      .cur_pitch       (cur_pitch)
   );

   assign obs = {sound, busy, note_ready, note_done, cur_pitch};

   always #5 clk = ~clk;

   // Bound the whole run
   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int half_of(int p, int o);
      int base;
      int h;
      case (p)
         1: base = 3058;  2: base = 2886;  3: base = 2724;  4: base = 2571;
         5: base = 2427;  6: base = 2290;  7: base = 2162;  8: base = 2041;
         9: base = 1926; 10: base = 1818; 11: base = 1716; 12: base = 1620;
         default: base = 0;
      endcase
      h = base / (1 << o);
      if (h < 1) h = 1;
      return h;
   endfunction

   function automatic int note_len(int d, int t);
      int te;
      te = (t == 0) ? 1 : t;
      return d * te + ((GAP_MS == 0) ? 1 : GAP_MS * te);
   endfunction

   // Expected outputs during cycle k after the accept edge (k = 1 is the first)
   function automatic logic [7:0] model_out(int k, int p, int o, int d, int t);
      int   te;
      int   pl;
      int   gl;
      logic s;
      te = (t == 0) ? 1 : t;
      pl = d * te;
      gl = (GAP_MS == 0) ? 1 : GAP_MS * te;
      if (k >= 1 && k <= pl) begin
         if (p == 0 || p > 12) return {4'b0100, 4'd0};
         s = (((k - 1) / half_of(p, o)) % 2) == 1;
         return {s, 3'b100, 4'(p)};
      end else if (k > pl && k <= pl + gl) begin
         return {3'b010, (k == pl + gl), 4'd0};
      end
      return IDLE_V;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic apply_note(int p, int o, int d, int t);
      note_pitch      = 4'(p);
      note_octave     = 3'(o);
      note_dur_ms     = DUR_W'(d);
      ticks_per_milli = 16'(t);
      note_valid      = 1'b1;
   endtask

   // Garbage on the command inputs must not disturb a note already latched
   task automatic scramble();
      ticks_per_milli = 16'($urandom);
      note_pitch      = 4'($urandom);
      note_octave     = 3'($urandom);
      note_dur_ms     = DUR_W'($urandom);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL reset_held i=%0d got=%b want=%b", i, obs, IDLE_V);
         end
      end
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL reset_idle i=%0d got=%b want=%b", i, obs, IDLE_V);
         end
      end
   endtask

   task automatic test_tone();
      logic [7:0] want;
      int len;
      len = note_len(2, 100);
      apply_note(10, 4, 2, 100);
      for (int k = 1; k <= len + 1; k++) begin
         @(negedge clk);
         want = model_out(k, 10, 4, 2, 100);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL tone k=%0d got=%b want=%b", k, obs, want);
         end
         if (k == 1) begin
            note_valid = 1'b0;
            scramble();
         end
      end
   endtask

   // Rests, zero duration, zero tpm, highest octave
   task automatic test_edges();
      int tp[6];
      int to[6];
      int td[6];
      int tt[6];
      logic [7:0] want;
      tp = '{0, 14, 5, 7, 12, 10};
      to = '{2, 0, 2, 7, 7, 7};
      td = '{3, 2, 0, 3, 2, 1};
      tt = '{4, 3, 3, 0, 20, 30};
      for (int n = 0; n < 6; n++) begin
         apply_note(tp[n], to[n], td[n], tt[n]);
         for (int k = 1; k <= note_len(td[n], tt[n]) + 1; k++) begin
            @(negedge clk);
            want = model_out(k, tp[n], to[n], td[n], tt[n]);
            checks++;
            if (obs !== want) begin
               errors++;
               $display("FAIL edge n=%0d k=%0d got=%b want=%b", n, k, obs, want);
            end
            if (k == 1) begin
               note_valid = 1'b0;
               scramble();
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] want;
      int len1;
      int len2;
      len1 = note_len(2, 5);
      len2 = note_len(1, 7);
      apply_note(3, 6, 2, 5);
      // valid stays high for the whole first note; ready must keep it out
      for (int k = 1; k <= len1; k++) begin
         @(negedge clk);
         want = model_out(k, 3, 6, 2, 5);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL b2b_first k=%0d got=%b want=%b", k, obs, want);
         end
         if (k == 1) scramble();
      end
      @(negedge clk);
      checks++;
      if (obs !== IDLE_V) begin
         errors++;
         $display("FAIL b2b_gap_idle got=%b want=%b", obs, IDLE_V);
      end
      apply_note(9, 5, 1, 7);
      for (int k = 1; k <= len2 + 1; k++) begin
         @(negedge clk);
         want = model_out(k, 9, 5, 1, 7);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL b2b_second k=%0d got=%b want=%b", k, obs, want);
         end
         if (k == 1) begin
            note_valid = 1'b0;
            scramble();
         end
      end
   endtask

   task automatic test_stop();
      logic [7:0] want;
      apply_note(12, 7, 3, 10);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         want = model_out(k, 12, 7, 3, 10);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL stop_play k=%0d got=%b want=%b", k, obs, want);
         end
         if (k == 1) note_valid = 1'b0;
      end
      stop = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== IDLE_V) begin
         errors++;
         $display("FAIL stop_abort got=%b want=%b", obs, IDLE_V);
      end
      // stop in IDLE blocks a simultaneous command
      apply_note(5, 6, 2, 3);
      @(negedge clk);
      checks++;
      if (obs !== IDLE_V) begin
         errors++;
         $display("FAIL stop_blocks_accept got=%b want=%b", obs, IDLE_V);
      end
      stop       = 1'b0;
      note_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== IDLE_V) begin
            errors++;
            $display("FAIL stop_quiet i=%0d got=%b want=%b", i, obs, IDLE_V);
         end
      end
      apply_note(4, 5, 1, 3);
      for (int k = 1; k <= note_len(1, 3) + 1; k++) begin
         @(negedge clk);
         want = model_out(k, 4, 5, 1, 3);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL stop_after k=%0d got=%b want=%b", k, obs, want);
         end
         if (k == 1) note_valid = 1'b0;
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] want;
      apply_note(2, 6, 1, 2);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         want = model_out(k, 2, 6, 1, 2);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL async_pre k=%0d got=%b want=%b", k, obs, want);
         end
         if (k == 1) note_valid = 1'b0;
      end
      // Mid-GAP, between clock edges
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== IDLE_V) begin
         errors++;
         $display("FAIL async_rst got=%b want=%b", obs, IDLE_V);
      end
      @(negedge clk);
      rst = 1'b0;
      apply_note(11, 7, 2, 6);
      for (int k = 1; k <= note_len(2, 6) + 1; k++) begin
         @(negedge clk);
         want = model_out(k, 11, 7, 2, 6);
         checks++;
         if (obs !== want) begin
            errors++;
            $display("FAIL async_after k=%0d got=%b want=%b", k, obs, want);
         end
         if (k == 1) note_valid = 1'b0;
      end
   endtask

   task automatic test_random();
      logic [7:0] want;
      int p;
      int o;
      int d;
      int t;
      for (int n = 0; n < 25; n++) begin
         p = $urandom_range(0, 15);
         o = $urandom_range(3, 7);
         d = $urandom_range(0, 5);
         t = $urandom_range(0, 8);
         apply_note(p, o, d, t);
         for (int k = 1; k <= note_len(d, t) + 1; k++) begin
            @(negedge clk);
            want = model_out(k, p, o, d, t);
            checks++;
            if (obs !== want) begin
               errors++;
               $display("FAIL rand n=%0d p=%0d o=%0d d=%0d t=%0d k=%0d got=%b want=%b",
                        n, p, o, d, t, k, obs, want);
            end
            if (k == 1) begin
               note_valid = 1'b0;
               scramble();
            end
         end
      end
   endtask

   initial begin
      rst             = 1'b1;
      note_valid      = 1'b0;
      stop            = 1'b0;
      ticks_per_milli = 16'd100;
      note_pitch      = 4'd0;
      note_octave     = 3'd0;
      note_dur_ms     = '0;

      test_reset();
      test_tone();
      test_edges();
      test_back_to_back();
      test_stop();
      test_async_reset();
      test_random();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
